// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit and its surroundings: the control/system
// bus used to read the program ROM, the redirect request from execute, and
// the decoded-instruction handshake towards execute.
interface instr_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 14
);
    logic              run_en;
    logic [1:0]        dev_sel;
    logic [ADDR_W-1:0] opaddr;
    logic [WORD_W-1:0] sys_data;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        opcode;
    logic [1:0]        amode;
    logic [3:0]        op0;
    logic [3:0]        op1;
    logic [ADDR_W-1:0] instr_pc;
    logic              halted;

    // The fetch unit itself
    modport master (
        input  run_en, sys_data, jump_valid, jump_addr, instr_ready,
        output dev_sel, opaddr, instr_valid, opcode, amode, op0, op1,
        instr_pc, halted
    );

    // Everything around the fetch unit (bus, ROM, execute stage)
    modport slave (
        output run_en, sys_data, jump_valid, jump_addr, instr_ready,
        input  dev_sel, opaddr, instr_valid, opcode, amode, op0, op1,
        instr_pc, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Reads one word from the program ROM per request
// cycle, splits it into opcode/amode/op0/op1 and presents it to the execute
// stage with a valid/ready handshake. A consumed HALT_OP stops fetching until
// a jump redirect arrives; a redirect always wins over anything else.
module instr_fetch #(
    parameter int         ADDR_W  = 4,
    parameter int         WORD_W  = 14,
    parameter logic [3:0] HALT_OP = 4'hF,
    parameter logic [1:0] ROM_DEV = 2'b11
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nx;
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] ir_nx;
    logic [ADDR_W-1:0] ipc;
    logic [ADDR_W-1:0] ipc_nx;
    logic              handshake;

    assign handshake = (state == VALID) && bus.instr_ready;

    // State, program counter and instruction register update with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            ipc   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
            ipc   <= ipc_nx;
        end
    end

    // Next-state logic; a jump overrides whatever the current state would do
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        ipc_nx   = ipc;

        case (state)
            IDLE: begin
                if (bus.run_en) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                ir_nx    = bus.sys_data;
                ipc_nx   = pc;
                pc_nx    = pc + 1'b1;
                state_nx = VALID;
            end
            VALID: begin
                if (handshake) begin
                    if (ir[WORD_W-1 -: 4] == HALT_OP) begin
                        state_nx = HALT;
                    end else if (bus.run_en) begin
                        state_nx = REQ;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (bus.jump_valid) begin
            pc_nx    = bus.jump_addr;
            ir_nx    = ir;
            ipc_nx   = ipc;
            state_nx = bus.run_en ? REQ : IDLE;
        end
    end

    // The ROM is only addressed during a request cycle; otherwise the bus is released
    assign bus.dev_sel     = (state == REQ) ? ROM_DEV : 2'b00;
    assign bus.opaddr      = (state == REQ) ? pc : '0;
    assign bus.instr_valid = (state == VALID);
    assign bus.halted      = (state == HALT);
    assign bus.opcode      = ir[13:10];
    assign bus.amode       = ir[9:8];
    assign bus.op0         = ir[7:4];
    assign bus.op1         = ir[3:0];
    assign bus.instr_pc    = ipc;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by a randomized run,
// all compared against a transaction-level reference of the fetch rules.
module tb_instr_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [13:0] rom [16];

    // Reference model state
    int          m_pc;
    bit          m_fetch;
    bit          m_pending;
    bit          m_stopped;
    logic [13:0] m_ir;
    int          m_ipc;

    instr_fetch_if #(.ADDR_W(4), .WORD_W(14)) bus ();

    instr_fetch #(
        .ADDR_W (4),
        .WORD_W (14),
        .HALT_OP(4'hF),
        .ROM_DEV(2'b11)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Program ROM answers whatever address the fetch unit drives
    assign bus.sys_data = rom[bus.opaddr];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit run, input bit jv,
                                 input int ja, input bit rdy);
        rst_n           = rst;
        bus.run_en      = run;
        bus.jump_valid  = jv;
        bus.jump_addr   = 4'(ja);
        bus.instr_ready = rdy;
    endtask

    // Advance the reference by one clock edge using the inputs held across it
    task automatic modelEdge();
        if (!rst_n) begin
            m_pc = 0; m_fetch = 0; m_pending = 0; m_stopped = 0;
            m_ir = '0; m_ipc = 0;
        end else if (bus.jump_valid) begin
            m_pc      = int'(bus.jump_addr);
            m_pending = 0;
            m_stopped = 0;
            m_fetch   = bus.run_en;
        end else if (m_fetch) begin
            m_ir      = rom[m_pc];
            m_ipc     = m_pc;
            m_pc      = (m_pc + 1) % 16;
            m_fetch   = 0;
            m_pending = 1;
        end else if (m_pending) begin
            if (bus.instr_ready) begin
                m_pending = 0;
                if (m_ir[13:10] == 4'hF) m_stopped = 1;
                else m_fetch = bus.run_en;
            end
        end else if (!m_stopped) begin
            m_fetch = bus.run_en;
        end
    endtask

    task automatic checkOutput();
        chk("dev_sel",     32'(bus.dev_sel),     m_fetch ? 32'd3 : 32'd0);
        chk("opaddr",      32'(bus.opaddr),      m_fetch ? 32'(m_pc) : 32'd0);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_pending));
        chk("halted",      32'(bus.halted),      32'(m_stopped));
        chk("opcode",      32'(bus.opcode),      32'(m_ir[13:10]));
        chk("amode",       32'(bus.amode),       32'(m_ir[9:8]));
        chk("op0",         32'(bus.op0),         32'(m_ir[7:4]));
        chk("op1",         32'(bus.op1),         32'(m_ir[3:0]));
        chk("instr_pc",    32'(bus.instr_pc),    32'(m_ipc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        modelEdge();
        checkOutput();
    endtask

    initial begin
        int guard;
        checks = 0;
        errors = 0;
        m_pc = 0; m_fetch = 0; m_pending = 0; m_stopped = 0; m_ir = '0; m_ipc = 0;

        // Directed ROM image: opcode equals address (never F) except word 8
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'(i % 15), 10'($urandom)};
        end
        rom[0]  = 14'h00A;
        rom[8]  = 14'h3C12;
        rom[15] = 14'h0123;

        // Reset
        applyStimulus(0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_dev_sel", 32'(bus.dev_sel), 32'd0);
        chk("reset_valid",   32'(bus.instr_valid), 32'd0);

        // First fetch of word 0
        applyStimulus(1, 1, 0, 0, 1);
        step();
        chk("first_req_dev_sel", 32'(bus.dev_sel), 32'd3);
        chk("first_req_opaddr",  32'(bus.opaddr), 32'd0);
        step();
        chk("first_valid", 32'(bus.instr_valid), 32'd1);
        chk("first_op1",   32'(bus.op1), 32'hA);
        chk("first_pc",    32'(bus.instr_pc), 32'd0);

        // Execute stalls for five cycles
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid",   32'(bus.instr_valid), 32'd1);
            chk("stall_dev_sel", 32'(bus.dev_sel), 32'd0);
            chk("stall_op1",     32'(bus.op1), 32'hA);
        end
        applyStimulus(1, 1, 0, 0, 1);
        step();
        chk("after_stall_opaddr", 32'(bus.opaddr), 32'd1);

        // Jump during a request to the last word, then wrap
        applyStimulus(1, 1, 1, 15, 1);
        step();
        chk("jump15_opaddr", 32'(bus.opaddr), 32'd15);
        applyStimulus(1, 1, 0, 0, 1);
        step();
        chk("word15_pc", 32'(bus.instr_pc), 32'd15);
        step();
        chk("wrap_opaddr", 32'(bus.opaddr), 32'd0);
        chk("wrap_dev_sel", 32'(bus.dev_sel), 32'd3);

        // Run on until the request for address 3
        guard = 0;
        while (!(bus.dev_sel == 2'b11 && bus.opaddr == 4'd3) && guard < 20) begin
            step();
            guard++;
        end
        chk("reach_req3", 32'(guard < 20), 32'd1);
        applyStimulus(1, 1, 1, 7, 1);
        step();
        chk("jump7_opaddr", 32'(bus.opaddr), 32'd7);
        chk("jump7_valid",  32'(bus.instr_valid), 32'd0);
        applyStimulus(1, 1, 0, 0, 1);
        step();
        chk("jump7_instr_pc", 32'(bus.instr_pc), 32'd7);

        // Word 8 carries the halt opcode
        step();
        step();
        chk("halt_word_opcode", 32'(bus.opcode), 32'hF);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halted_flag",    32'(bus.halted), 32'd1);
            chk("halted_dev_sel", 32'(bus.dev_sel), 32'd0);
        end
        applyStimulus(1, 1, 1, 2, 1);
        step();
        chk("unhalt_flag",   32'(bus.halted), 32'd0);
        chk("unhalt_opaddr", 32'(bus.opaddr), 32'd2);

        // Reset while an instruction is presented
        applyStimulus(1, 1, 0, 0, 0);
        step();
        chk("pre_reset_valid", 32'(bus.instr_valid), 32'd1);
        applyStimulus(0, 1, 0, 0, 1);
        step();
        chk("reset_mid_valid", 32'(bus.instr_valid), 32'd0);
        applyStimulus(1, 1, 0, 0, 1);
        step();
        chk("post_reset_opaddr", 32'(bus.opaddr), 32'd0);

        // Jump coincident with the handshake of a halt instruction
        applyStimulus(1, 1, 1, 8, 0);
        step();
        applyStimulus(1, 1, 0, 0, 0);
        step();
        chk("coinc_opcode", 32'(bus.opcode), 32'hF);
        applyStimulus(1, 1, 1, 5, 1);
        step();
        chk("coinc_halted", 32'(bus.halted), 32'd0);
        chk("coinc_opaddr", 32'(bus.opaddr), 32'd5);

        // Randomized traffic with a fully random ROM
        for (int i = 0; i < 16; i++) begin
            rom[i] = 14'($urandom);
        end
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 99) < 8,
                          int'($urandom_range(0, 15)),
                          $urandom_range(0, 9) < 6);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: ADDR_W, 4, program address width; program space 2**ADDR_W words.
REQ-002 Parameter: WORD_W, 14, instruction word width.
REQ-003 Parameter: HALT_OP, 4'hF, opcode that halts fetch when consumed.
REQ-004 Parameter: ROM_DEV, 2'b11, device select code of the program ROM.
REQ-005 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port: run_en  input  1  permits new fetches.
REQ-008 Port: dev_sel  output  2  device select to control bus.
REQ-009 Port: opaddr  output  ADDR_W  ROM word address to control bus.
REQ-010 Port: sys_data  input  WORD_W  instruction word returned on system bus.
REQ-011 Port: jump_valid  input  1  redirect request from execute stage.
REQ-012 Port: jump_addr  input  ADDR_W  redirect target.
REQ-013 Port: instr_valid  output  1  decoded instruction available.
REQ-014 Port: instr_ready  input  1  execute stage accepts instruction.
REQ-015 Port: opcode / amode / op0 / op1  output  4 / 2 / 4 / 4  fields sys_data[13:10] / [9:8] / [7:4] / [3:0].
REQ-016 Port: instr_pc  output  ADDR_W  address the presented instruction was fetched from.
REQ-017 Port: halted  output  1  fetch stopped on HALT_OP.

Function
REQ-018 FSM states IDLE, REQ, VALID, HALT shall be the only states.
REQ-019 IDLE: dev_sel=2'b00; go to REQ when run_en=1.
REQ-020 REQ: dev_sel=ROM_DEV, opaddr=pc, for exactly one cycle.
REQ-021 At end of REQ: latch sys_data into instruction register, instr_pc<=pc, pc<=pc+1, go to VALID.
REQ-022 pc increment shall wrap modulo 2**ADDR_W (2**ADDR_W-1 -> 0), no flag.
REQ-023 VALID: instr_valid=1; fields and instr_pc held stable until handshake.
REQ-024 Handshake completes in a cycle with instr_valid=1 and instr_ready=1; then opcode==HALT_OP -> HALT, else run_en=1 -> REQ, else IDLE.
REQ-025 Steady-state throughput: one instruction per 2 cycles; REQ-to-instr_valid latency 1 cycle.
REQ-026 dev_sel shall be 2'b00 and opaddr 0 in every state except REQ (bus released).
REQ-027 HALT: halted=1, no fetches; leave only on jump_valid or reset.
REQ-028 jump_valid=1 in any state has priority: pc<=jump_addr, instr_valid=0 next cycle, halted=0, next state REQ if run_en=1 else IDLE.
REQ-029 jump_valid during REQ: latched word discarded, pc not incremented.
REQ-030 jump_valid coincident with handshake: instruction counts as consumed, jump taken, HALT_OP ignored.
REQ-031 run_en low in VALID: current instruction still presented until handshake.
REQ-032 instr_ready while instr_valid=0: ignored.

Reset
REQ-033 rst_n=0 at a clock edge: state=IDLE, pc=0, instruction register=0, instr_pc=0, instr_valid=0, halted=0, dev_sel=2'b00, opaddr=0.
REQ-034 Reset mid-fetch or mid-handshake: pending instruction dropped, no handshake completes in that cycle.

Verification
REQ-035 Reset, run_en=1, ROM word0=14'h00A (MOV,REG,0,A), instr_ready=1 -> cycle1 dev_sel=11 opaddr=0; cycle2 instr_valid=1 opcode/amode/op0/op1 per word0, instr_pc=0.
REQ-036 instr_ready=0 for 5 cycles in VALID -> fields stable, dev_sel=00, no further REQ; ready=1 -> next REQ opaddr=1.
REQ-037 pc=15 fetched and consumed -> next REQ opaddr=0.
REQ-038 jump_valid=1 jump_addr=7 during REQ for addr 3 -> next cycle REQ opaddr=7, instr_pc=7 on the following valid.
REQ-039 Word with opcode 4'hF consumed -> halted=1, dev_sel=00 for 10 cycles; jump_valid addr 2 -> halted=0, REQ opaddr=2.
REQ-040 rst_n=0 while instr_valid=1 -> next cycle instr_valid=0, state IDLE, pc=0.
